bus_reg_bank: RTL and testbench
===============================

// Module: bus_reg_bank
// PURPOSE
//  Parametrised bank of NREGS clocked registers, each WIDTH bits, on one shared tri-state bus.
//  - External control reads or writes any register over the bus.
//  - A built-in move sequencer copies one register to another over the same bus without an external controller.
//  - Sits on the datapath bus beside the ALU and control FSM; replaces hand-instantiated per-register latches.
// PARAMETERS
//  WIDTH  3  bus and register width, bits (>=1)
//  NREGS  4  number of registers (>=2); AW = max(1,$clog2(NREGS)) is a localparam
// PORTS
//  clk      in     1      rising-edge clock
//  rst      in     1      reset: synchronous, active-high
//  bus      inout  WIDTH  shared tri-state bus
//  ext_wr   in     1      capture bus into R[ext_addr] at clock edge
//  ext_rd   in     1      drive R[ext_addr] onto bus
//  ext_addr in     AW     register index for ext_wr/ext_rd
//  mv_start in     1      request move R[mv_src] -> R[mv_dst]
//  mv_src   in     AW     move source index
//  mv_dst   in     AW     move destination index
//  mv_busy  out    1      sequencer not IDLE
//  mv_done  out    1      1-cycle pulse: move complete
//  err      out    1      1-cycle pulse: request rejected
// BEHAVIOUR
//  - Storage is edge-triggered flops, not latches; all state changes on posedge clk.
//  - Reset (rst=1 at edge): R[*]=0, state=IDLE, mv_done=0, err=0, mv_busy=0.
//    While rst=1 the bus is Z combinationally, even mid-move; any in-flight move is discarded.
//  - Bus drive:
//    - Driven only in IDLE with ext_rd=1 and a valid ext_addr (bus=R[ext_addr]), or by the sequencer per state below.
//    - Otherwise Z. Never two internal drivers at once.
//  - ext_wr in IDLE with valid addr: R[ext_addr] <= bus at the edge.
//    - ext_rd and ext_wr together on the same addr: register keeps its value (self-loop).
//  - Invalid index: any addr >= NREGS on an active op. The op is dropped, no drive, and err pulses the next cycle.
//  - FSM states: IDLE, DRIVE, DONE.
//    - IDLE: mv_start with valid src/dst latches src/dst and goes to DRIVE.
//      - mv_start has priority: ext_rd/ext_wr in that cycle are dropped and err pulses.
//    - DRIVE: bus=R[src]; at the edge R[dst] <= bus; go to DONE.
//    - DONE: bus Z, mv_done=1, go to IDLE.
//  - Latency: start sampled at edge 0; mv_done high in the cycle after edge 1; 2 cycles total. Back-to-back start is legal from DONE+1.
//  - mv_busy = (state != IDLE), combinational from the state register.
//  - Any mv_start/ext_rd/ext_wr while busy is ignored and err pulses. Registers are untouched.
//  - src==dst is legal: register unchanged, mv_done still pulses.
//  - External agents must not drive bus while mv_busy=1; contention is not detected.
// CONFIGURATION
//  BUS_REG_SWAP_EN defined:
//  - Adds input mv_swap (1 bit), sampled with mv_start.
//  - If set, the sequencer runs IDLE->SW_A->SW_B->SW_T->DONE, using an internal WIDTH-bit tmp:
//    - SW_A: bus=R[src], tmp<=bus.
//    - SW_B: bus=R[dst], R[src]<=bus.
//    - SW_T: bus=tmp, R[dst]<=bus.
//  - Swap latency is 4 cycles to mv_done; tmp resets to 0.
//  Undefined: mv_swap port and SW_* states are absent; behaviour is exactly as above.
// TESTING
//  1 rst=1 one edge, then ext_rd each addr -> bus reads 0 for all regs; mv_busy=0, err=0.
//  2 WIDTH=3: bus driven 3'b101 with ext_wr addr2, then ext_rd addr2 -> bus=3'b101; other regs still 0.
//  3 R1=6, R3=0; mv_start src1 dst3 -> bus=6 in DRIVE cycle, mv_done next cycle, R3=6, R1=6.
//  4 mv_start while busy, and ext_wr while busy -> err pulses, R unchanged; original move completes normally.
//  5 ext_addr=NREGS (NREGS=5, AW=3, addr 5) with ext_wr -> err pulse, no reg changes, bus Z.
//  6 rst asserted during DRIVE -> bus Z immediately, after edge all R=0, state IDLE, no mv_done;
//    with BUS_REG_SWAP_EN, R0=2 R1=5 swap -> R0=5 R1=2, mv_done 4 cycles after start.

Source files
------------

// File: rtl/bus_reg_bank.sv
// bus_reg_bank: NREGS x WIDTH register bank on one shared tri-state bus,
// with external read/write access and a built-in register-to-register
// move sequencer.
// Ports: clk, rst (sync, active-high), bus (inout WIDTH),
//   ext_wr/ext_rd/ext_addr (external access), mv_start/mv_src/mv_dst
//   (move request), mv_busy, mv_done, err (status).
// Option: define BUS_REG_SWAP_EN to add mv_swap and the SW_A/SW_B/SW_T
//   swap sequence through an internal tmp register.
module bus_reg_bank #(
  parameter int WIDTH = 3,
  parameter int NREGS = 4,
  localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire logic [WIDTH-1:0] bus,
  input  logic             ext_wr,
  input  logic             ext_rd,
  input  logic [AW-1:0]    ext_addr,
  input  logic             mv_start,
  input  logic [AW-1:0]    mv_src,
  input  logic [AW-1:0]    mv_dst,
`ifdef BUS_REG_SWAP_EN
  input  logic             mv_swap,
`endif
  output logic             mv_busy,
  output logic             mv_done,
  output logic             err
);

  localparam logic [AW:0] NR = NREGS[AW:0];

`ifdef BUS_REG_SWAP_EN
  typedef enum logic [2:0] {
    IDLE, DRIVE, DONE, SW_A, SW_B, SW_T
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DRIVE, DONE
  } state_t;
`endif

  state_t state, state_d;

  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    src_q, dst_q;
  logic             ld;

  logic             drv;
  logic [AW-1:0]    rd_idx;
  logic             bus_oe;

  logic             we;
  logic [AW-1:0]    wr_idx;
  logic             err_d;
  logic             req;

`ifdef BUS_REG_SWAP_EN
  logic [WIDTH-1:0] tmp;
  logic             tmp_we;
  logic             tmp_drv;
`endif

  function automatic logic ok(input logic [AW-1:0] a);
    return {1'b0, a} < NR;
  endfunction

  assign req     = mv_start | ext_rd | ext_wr;
  assign mv_busy = (state != IDLE);
  assign mv_done = (state == DONE);

  // Reset overrides every driver so the bus floats while rst is high.
  assign bus_oe = drv & ~rst;

`ifdef BUS_REG_SWAP_EN
  assign bus = bus_oe ? (tmp_drv ? tmp : regs[rd_idx])
                      : {WIDTH{1'bz}};
`else
  assign bus = bus_oe ? regs[rd_idx] : {WIDTH{1'bz}};
`endif

  always_comb begin
    state_d = state;
    ld      = 1'b0;
    drv     = 1'b0;
    rd_idx  = '0;
    we      = 1'b0;
    wr_idx  = '0;
    err_d   = 1'b0;
`ifdef BUS_REG_SWAP_EN
    tmp_we  = 1'b0;
    tmp_drv = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (mv_start) begin
          // A move request wins; same-cycle external ops are dropped.
          if (ok(mv_src) && ok(mv_dst)) begin
            ld    = 1'b1;
            err_d = ext_rd | ext_wr;
`ifdef BUS_REG_SWAP_EN
            state_d = mv_swap ? SW_A : DRIVE;
`else
            state_d = DRIVE;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (ext_rd) begin
            if (ok(ext_addr)) begin
              drv    = 1'b1;
              rd_idx = ext_addr;
            end else begin
              err_d = 1'b1;
            end
          end
          if (ext_wr) begin
            if (ok(ext_addr)) begin
              we     = 1'b1;
              wr_idx = ext_addr;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      DRIVE: begin
        drv     = 1'b1;
        rd_idx  = src_q;
        we      = 1'b1;
        wr_idx  = dst_q;
        err_d   = req;
        state_d = DONE;
      end
      DONE: begin
        err_d   = req;
        state_d = IDLE;
      end
`ifdef BUS_REG_SWAP_EN
      SW_A: begin
        drv     = 1'b1;
        rd_idx  = src_q;
        tmp_we  = 1'b1;
        err_d   = req;
        state_d = SW_B;
      end
      SW_B: begin
        drv     = 1'b1;
        rd_idx  = dst_q;
        we      = 1'b1;
        wr_idx  = src_q;
        err_d   = req;
        state_d = SW_T;
      end
      SW_T: begin
        drv     = 1'b1;
        tmp_drv = 1'b1;
        we      = 1'b1;
        wr_idx  = dst_q;
        err_d   = req;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err   <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
    end else begin
      state <= state_d;
      err   <= err_d;
      if (ld) begin
        src_q <= mv_src;
        dst_q <= mv_dst;
      end
    end
  end

  // Writes capture the resolved bus, so a read and write of the same
  // register in one cycle leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_idx] <= bus;
    end
  end

`ifdef BUS_REG_SWAP_EN
  always_ff @(posedge clk) begin
    if (rst) tmp <= '0;
    else if (tmp_we) tmp <= bus;
  end
`endif

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank: directed self-checking bench for bus_reg_bank
// (WIDTH=3, NREGS=5 so that out-of-range indices exist).
module tb_bus_reg_bank;

  localparam int W  = 3;
  localparam int N  = 5;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  wire  [W-1:0]  bus;
  logic          ext_wr, ext_rd;
  logic [AW-1:0] ext_addr;
  logic          mv_start;
  logic [AW-1:0] mv_src, mv_dst;
  logic          mv_swap;
  logic          mv_busy, mv_done, err;

  logic          tb_en;
  logic [W-1:0]  tb_drv;

  int checks = 0;
  int errors = 0;

  assign bus = tb_en ? tb_drv : {W{1'bz}};

  always #10 clk = ~clk;

  bus_reg_bank #(.WIDTH(W), .NREGS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ext_wr   (ext_wr),
    .ext_rd   (ext_rd),
    .ext_addr (ext_addr),
    .mv_start (mv_start),
    .mv_src   (mv_src),
    .mv_dst   (mv_dst),
`ifdef BUS_REG_SWAP_EN
    .mv_swap  (mv_swap),
`endif
    .mv_busy  (mv_busy),
    .mv_done  (mv_done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input int exp, input string tag);
    ext_rd   = 1'b1;
    ext_addr = AW'(a);
    #1;
    chk({tag, "_oe"}, 32'(dut.bus_oe), 1);
    chk(tag, 32'(bus), 32'(exp));
    ext_rd = 1'b0;
  endtask

  task automatic wr(input int a, input int v);
    tb_en    = 1'b1;
    tb_drv   = W'(v);
    ext_wr   = 1'b1;
    ext_addr = AW'(a);
    tick();
    tb_en  = 1'b0;
    ext_wr = 1'b0;
  endtask

  task automatic status(input string tag, input int b, input int d,
                        input int e);
    chk({tag, "_busy"}, 32'(mv_busy), 32'(b));
    chk({tag, "_done"}, 32'(mv_done), 32'(d));
    chk({tag, "_err"},  32'(err),     32'(e));
  endtask

  task automatic start(input int s, input int d);
    mv_start = 1'b1;
    mv_src   = AW'(s);
    mv_dst   = AW'(d);
    tick();
    mv_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ext_wr = 0; ext_rd = 0; ext_addr = 0;
    mv_start = 0; mv_src = 0; mv_dst = 0; mv_swap = 0;
    tb_en = 0; tb_drv = 0;

    // 1: reset
    tick();
    rst = 1'b0;
    status("rst", 0, 0, 0);
    for (int a = 0; a < N; a++) rd(a, 0, $sformatf("rst_r%0d", a));
    tick();
    chk("rst_err_after_reads", 32'(err), 0);

    // 2: external write / read
    wr(2, 5);
    rd(2, 5, "wr_r2");
    rd(0, 0, "wr_r0");
    rd(1, 0, "wr_r1");
    rd(3, 0, "wr_r3");
    rd(4, 0, "wr_r4");

    // 3: move R1 -> R3
    wr(1, 6);
    start(1, 3);
    status("mv_drive", 1, 0, 0);
    chk("mv_drive_oe", 32'(dut.bus_oe), 1);
    chk("mv_drive_bus", 32'(bus), 6);
    tick();
    status("mv_done", 1, 1, 0);
    chk("mv_done_oe", 32'(dut.bus_oe), 0);
    tick();
    status("mv_idle", 0, 0, 0);
    rd(3, 6, "mv_r3");
    rd(1, 6, "mv_r1");

    // 4: requests while busy are rejected
    start(2, 0);
    mv_start = 1'b1; mv_src = 1; mv_dst = 4;
    ext_wr = 1'b1; ext_addr = 4;
    tick();
    mv_start = 1'b0; ext_wr = 1'b0;
    status("busy_rej", 1, 1, 1);
    tick();
    status("busy_after", 0, 0, 0);
    rd(0, 5, "busy_r0");
    rd(4, 0, "busy_r4");
    rd(1, 6, "busy_r1");

    // 5: out-of-range index
    tb_en = 1'b1; tb_drv = 3'd7;
    ext_wr = 1'b1; ext_addr = 3'd5;
    tick();
    tb_en = 1'b0; ext_wr = 1'b0;
    chk("bad_wr_err", 32'(err), 1);
    ext_rd = 1'b1; ext_addr = 3'd6;
    #1;
    chk("bad_rd_oe", 32'(dut.bus_oe), 0);
    tick();
    ext_rd = 1'b0;
    chk("bad_rd_err", 32'(err), 1);
    start(7, 0);
    status("bad_mv", 0, 0, 1);
    tick();
    chk("bad_err_clear", 32'(err), 0);
    for (int a = 0; a < N; a++)
      rd(a, (a == 4) ? 0 : ((a % 2 == 0) ? 5 : 6),
         $sformatf("bad_r%0d", a));

    // mv_start beats a same-cycle ext_rd
    mv_start = 1'b1; mv_src = 0; mv_dst = 4;
    ext_rd = 1'b1; ext_addr = 1;
    #1;
    chk("prio_oe", 32'(dut.bus_oe), 0);
    tick();
    mv_start = 1'b0; ext_rd = 1'b0;
    status("prio_drive", 1, 0, 1);
    chk("prio_bus", 32'(bus), 5);
    tick();
    status("prio_done", 1, 1, 0);
    tick();
    rd(4, 5, "prio_r4");

    // src == dst
    start(3, 3);
    tick();
    status("self_done", 1, 1, 0);
    tick();
    rd(3, 6, "self_r3");

    // read and write of one register together keeps its value
    ext_rd = 1'b1; ext_wr = 1'b1; ext_addr = 1;
    #1;
    chk("loop_bus", 32'(bus), 6);
    tick();
    ext_rd = 1'b0; ext_wr = 1'b0;
    rd(1, 6, "loop_r1");

    // 6: reset in the middle of a move
    start(1, 2);
    chk("rstmv_oe_pre", 32'(dut.bus_oe), 1);
    rst = 1'b1;
    #1;
    chk("rstmv_oe", 32'(dut.bus_oe), 0);
    tick();
    rst = 1'b0;
    status("rstmv", 0, 0, 0);
    tick();
    chk("rstmv_nodone", 32'(mv_done), 0);
    for (int a = 0; a < N; a++) rd(a, 0, $sformatf("rstmv_r%0d", a));

`ifdef BUS_REG_SWAP_EN
    wr(0, 2);
    wr(1, 5);
    mv_swap = 1'b1;
    start(0, 1);
    mv_swap = 1'b0;
    chk("sw_a_bus", 32'(bus), 2);
    chk("sw_1_done", 32'(mv_done), 0);
    tick();
    chk("sw_b_bus", 32'(bus), 5);
    chk("sw_2_done", 32'(mv_done), 0);
    tick();
    chk("sw_t_bus", 32'(bus), 2);
    chk("sw_3_done", 32'(mv_done), 0);
    tick();
    status("sw_done", 1, 1, 0);
    tick();
    rd(0, 5, "sw_r0");
    rd(1, 2, "sw_r1");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
